// File: rtl/calc_pkg.sv
// Shared calculator definitions: token codes, the token class helper and the
// sequencer state encoding.
package calc_pkg;

  localparam logic [7:0] TOK_END   = 8'd10;
  localparam logic [7:0] TOK_ADD   = 8'd20;
  localparam logic [7:0] TOK_SUB   = 8'd21;
  localparam logic [7:0] TOK_MUL   = 8'd22;
  localparam logic [7:0] TOK_DIV   = 8'd23;
  localparam logic [7:0] DIGIT_MIN = 8'd0;
  localparam logic [7:0] DIGIT_MAX = 8'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_FINISH
  } seq_state_e;

  typedef enum logic [1:0] {
    TC_DIGIT,
    TC_OP,
    TC_END,
    TC_INVALID
  } tok_class_e;

  function automatic tok_class_e tok_class(input logic [7:0] code);
    tok_class_e cls;
    // The subtraction form keeps the lower digit bound meaningful for unsigned codes
    if ((code - DIGIT_MIN) <= (DIGIT_MAX - DIGIT_MIN)) begin
      cls = TC_DIGIT;
    end else if (code == TOK_END) begin
      cls = TC_END;
    end else if ((code == TOK_ADD) || (code == TOK_SUB) ||
                 (code == TOK_MUL) || (code == TOK_DIV)) begin
      cls = TC_OP;
    end else begin
      cls = TC_INVALID;
    end
    return cls;
  endfunction

endpackage

// File: rtl/token_classifier.sv
// Combinational decode of an 8-bit keystroke code into one-hot class flags.
module token_classifier
  import calc_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output logic       is_op,
  output logic       is_end,
  output logic       is_invalid
);

  tok_class_e cls_s;

  // Map the class enum onto the individual flags
  always_comb begin
    cls_s      = tok_class(code);
    is_digit   = 1'b0;
    is_op      = 1'b0;
    is_end     = 1'b0;
    is_invalid = 1'b0;
    case (cls_s)
      TC_DIGIT: is_digit   = 1'b1;
      TC_OP:    is_op      = 1'b1;
      TC_END:   is_end     = 1'b1;
      default:  is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/rom_token_sequencer.sv
// Walks the keystroke ROM from index 0 and hands classified tokens to the
// calculator core over a valid/ready handshake.
module rom_token_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int IDX_W = 7,
  parameter int TOK_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] rom_index,
  input  logic [TOK_W-1:0] rom_data,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [TOK_W-1:0] tok_data,
  output logic             tok_is_op,
  output logic             tok_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] tok_cnt
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] CNT_MAX  = IDX_W'(DEPTH);

  seq_state_e state_r;
  logic       is_digit_s;
  logic       is_op_s;
  logic       is_end_s;
  logic       is_invalid_s;
  logic       tok_bad_s;
  logic       accept_s;

  token_classifier u_classifier (
    .code       (rom_data),
    .is_digit   (is_digit_s),
    .is_op      (is_op_s),
    .is_end     (is_end_s),
    .is_invalid (is_invalid_s)
  );

  // A code that decodes to no legal class is treated as invalid as well
  assign tok_bad_s = is_invalid_s | ~(is_digit_s | is_op_s | is_end_s);
  assign accept_s  = tok_valid & tok_ready;

  // Sequencer FSM with index counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      rom_index <= IDX_ZERO;
      tok_data  <= {TOK_W{1'b0}};
      tok_cnt   <= IDX_ZERO;
      tok_valid <= 1'b0;
      tok_is_op <= 1'b0;
      tok_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (abort) begin
      state_r   <= ST_IDLE;
      tok_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rom_index <= IDX_ZERO;
            tok_cnt   <= IDX_ZERO;
            err       <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ST_FETCH;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          tok_data  <= rom_data;
          tok_is_op <= is_op_s;
          tok_last  <= is_end_s;
          if (tok_bad_s) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            tok_valid <= 1'b1;
            state_r   <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (accept_s) begin
            tok_valid <= 1'b0;
            if (tok_cnt != CNT_MAX) begin
              tok_cnt <= tok_cnt + IDX_ONE;
            end else begin
              tok_cnt <= tok_cnt;
            end
            if (tok_last) begin
              done    <= 1'b1;
              state_r <= ST_FINISH;
            end else if (rom_index == LAST_IDX) begin
              // Ran off the end of the ROM without seeing an end marker
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              rom_index <= rom_index + IDX_ONE;
              state_r   <= ST_FETCH;
            end
          end else begin
            state_r <= ST_PRESENT;
          end
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          tok_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_token_sequencer.sv
// Randomized bench for rom_token_sequencer against a token-list reference model.
module tb_rom_token_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       tok_ready;
  logic       sel4;
  logic [7:0] rom_mem [0:127];

  logic [6:0] idx_a, cnt_a, idx_b, cnt_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, op_a, last_a, busy_a, done_a, err_a;
  logic       valid_b, op_b, last_b, busy_b, done_b, err_b;

  logic [6:0] o_idx, o_cnt;
  logic [7:0] o_data;
  logic       o_valid, o_op, o_last, o_busy, o_done, o_err;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  bit         exp_err;

  always #5 clk = ~clk;

  rom_token_sequencer #(.DEPTH(100), .IDX_W(7), .TOK_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel4), .abort(abort),
    .rom_index(idx_a), .rom_data(rom_mem[idx_a]),
    .tok_valid(valid_a), .tok_ready(tok_ready), .tok_data(data_a),
    .tok_is_op(op_a), .tok_last(last_a), .busy(busy_a), .done(done_a),
    .err(err_a), .tok_cnt(cnt_a)
  );

  rom_token_sequencer #(.DEPTH(4), .IDX_W(7), .TOK_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start & sel4), .abort(abort),
    .rom_index(idx_b), .rom_data(rom_mem[idx_b]),
    .tok_valid(valid_b), .tok_ready(tok_ready), .tok_data(data_b),
    .tok_is_op(op_b), .tok_last(last_b), .busy(busy_b), .done(done_b),
    .err(err_b), .tok_cnt(cnt_b)
  );

  always_comb begin
    o_idx   = sel4 ? idx_b   : idx_a;
    o_cnt   = sel4 ? cnt_b   : cnt_a;
    o_data  = sel4 ? data_b  : data_a;
    o_valid = sel4 ? valid_b : valid_a;
    o_op    = sel4 ? op_b    : op_a;
    o_last  = sel4 ? last_b  : last_a;
    o_busy  = sel4 ? busy_b  : busy_a;
    o_done  = sel4 ? done_b  : done_a;
    o_err   = sel4 ? err_b   : err_a;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the list of tokens the consumer should see, and the final error flag
  task automatic build_exp(input int depth);
    int c;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < depth; i++) begin
      c = int'(rom_mem[i]);
      if (!(c <= 9 || c == 10 || (c >= 20 && c <= 23))) begin
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back(c);
      if (c == 10) break;
      if (i == depth - 1) exp_err = 1'b1;
    end
  endtask

  task automatic load_rom(input int vals[$]);
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'd10;
    foreach (vals[i]) rom_mem[i] = 8'(vals[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, ":idx"},   o_idx,   0);
    check_val({tag, ":data"},  o_data,  0);
    check_val({tag, ":cnt"},   o_cnt,   0);
    check_val({tag, ":valid"}, o_valid, 0);
    check_val({tag, ":op"},    o_op,    0);
    check_val({tag, ":last"},  o_last,  0);
    check_val({tag, ":busy"},  o_busy,  0);
    check_val({tag, ":done"},  o_done,  0);
    check_val({tag, ":err"},   o_err,   0);
  endtask

  // Entered at a negedge with the DUT idle; drives one full sequence and checks it
  task automatic run_seq(input string tag, input bit rnd_rdy, input int abort_tok,
                         input int exp_done_cyc, input int depth);
    int         k, cyc;
    bit         hold_v, fin, aborted;
    logic [7:0] held;
    build_exp(depth);
    k = 0; cyc = 0; hold_v = 1'b0; fin = 1'b0; aborted = 1'b0; held = 8'd0;
    start = 1'b1; tok_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (!fin && cyc < 800) begin
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 1) begin
        check_val({tag, ":idx_start"}, o_idx, 0);
        check_val({tag, ":cnt_start"}, o_cnt, 0);
        check_val({tag, ":busy_start"}, o_busy, 1);
      end
      check_val({tag, ":idx_bound"}, 32'(int'(o_idx) <= depth - 1), 1);
      if (aborted) begin
        check_val({tag, ":abort_valid"}, o_valid, 0);
        check_val({tag, ":abort_busy"}, o_busy, 0);
        check_val({tag, ":abort_done"}, o_done, 0);
        check_val({tag, ":abort_err"}, o_err, 0);
        fin = 1'b1;
      end else if (o_done) begin
        check_val({tag, ":done_cnt"}, o_cnt, exp_q.size());
        check_val({tag, ":done_err"}, o_err, exp_err);
        check_val({tag, ":accepted"}, k, exp_q.size());
        if (exp_done_cyc > 0) check_val({tag, ":done_cycle"}, cyc, exp_done_cyc);
        start = 1'b1;
        fin = 1'b1;
      end else begin
        if (hold_v) begin
          check_val({tag, ":hold_valid"}, o_valid, 1);
          check_val({tag, ":hold_data"}, o_data, held);
        end
        if (cyc == 5) start = 1'b1;
        if (abort_tok >= 0 && k == abort_tok && o_valid) begin
          abort = 1'b1;
          tok_ready = 1'b0;
          aborted = 1'b1;
          hold_v = 1'b0;
        end else begin
          tok_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          if (o_valid && tok_ready) begin
            if (k < exp_q.size()) begin
              check_val({tag, ":tok_data"}, o_data, exp_q[k]);
              check_val({tag, ":tok_op"}, o_op, 32'(exp_q[k] >= 20 && exp_q[k] <= 23));
              check_val({tag, ":tok_last"}, o_last, 32'(exp_q[k] == 10));
            end else begin
              check_val({tag, ":extra_tok"}, k + 1, exp_q.size());
            end
            k++;
            hold_v = 1'b0;
          end else if (o_valid) begin
            hold_v = 1'b1;
            held = o_data;
          end else begin
            hold_v = 1'b0;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) check_val({tag, ":timeout"}, cyc, 0);
    start = 1'b0; abort = 1'b0; tok_ready = 1'b0;
    repeat (3) begin
      check_val({tag, ":post_done"}, o_done, 0);
      check_val({tag, ":post_busy"}, o_busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int vals[$];
    int len, r, guard;
    rst = 1'b0; start = 1'b0; abort = 1'b0; tok_ready = 1'b0; sel4 = 1'b0;
    load_rom('{5, 5, 21, 1, 10});
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_seq("basic", 1'b0, -1, 11, 100);
    run_seq("rnd_ready", 1'b1, -1, 0, 100);
    load_rom('{3, 7, 99});
    run_seq("invalid", 1'b1, -1, 0, 100);
    load_rom('{5, 5, 21, 1, 10});
    run_seq("abort", 1'b1, 1, 0, 100);
    run_seq("restart", 1'b1, -1, 0, 100);

    sel4 = 1'b1;
    load_rom('{1, 2, 3, 4, 10});
    run_seq("overrun4", 1'b1, -1, 0, 4);
    sel4 = 1'b0;

    for (int n = 0; n < 10; n++) begin
      vals.delete();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 13);
        vals.push_back(r < 10 ? r : 20 + (r - 10));
      end
      if ($urandom_range(0, 3) == 0) vals.push_back($urandom_range(24, 255));
      load_rom(vals);
      run_seq("random", 1'b1, -1, 0, 100);
    end

    // Asynchronous reset while a token is being presented
    load_rom('{4, 20, 6, 10});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tok_ready = 1'b0;
    guard = 0;
    while (!o_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("rst_pre_valid", o_valid, 1);
    #2 rst = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_token_sequencer.md
Name: rom_token_sequencer

Overview:
- Walks the keystroke ROM from index 0 and fetches each token.
- Classifies each token and hands it to the calculator core over a valid/ready handshake.
- Stops at the end marker '#' (code 10), or on an invalid code, or when the last ROM location is reached without an end marker.
- Sits between the keystroke ROM (combinational read) and the expression parser/ALU sequencer.

Parameters:
- DEPTH, 100, number of ROM locations; the highest valid index is DEPTH-1.
- IDX_W, 7, width of the ROM index.
- TOK_W, 8, width of a ROM token.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sequence from index 0; ignored unless the block is in IDLE.
- abort  in  1  synchronous cancel; the block returns to IDLE next cycle.
- rom_index  out  IDX_W  ROM address.
- rom_data  in  TOK_W  ROM output, valid in the same cycle as rom_index.
- tok_valid  out  1  token available on tok_data.
- tok_ready  in  1  consumer accepts the token.
- tok_data  out  TOK_W  registered token.
- tok_is_op  out  1  token is an operator (codes 20..23).
- tok_last  out  1  token is the end marker (code 10).
- busy  out  1  block is not in IDLE.
- done  out  1  one-cycle pulse when a sequence ends.
- err  out  1  sticky error flag; cleared by the next accepted start.
- tok_cnt  out  IDX_W  number of tokens accepted by the consumer in the current sequence.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - rom_index, tok_data and tok_cnt are 0.
  - tok_valid, tok_is_op, tok_last, busy, done and err are 0.
- Token classes:
  - Codes 0..9 are digits.
  - Code 10 is END.
  - Code 20 is '+', 21 is '-', 22 is '*', 23 is '/'.
  - Every other code is INVALID.
- States: IDLE, FETCH, PRESENT, FINISH.
- IDLE:
  - start=1: rom_index<=0, tok_cnt<=0, err<=0, go to FETCH.
- FETCH (one cycle):
  - Register rom_data into tok_data, and set tok_is_op and tok_last from the token class.
  - INVALID code: err<=1, go to FINISH; no token is presented.
  - Otherwise go to PRESENT.
- PRESENT:
  - tok_valid=1; tok_data, tok_is_op and tok_last are held stable until the token is accepted.
  - A token is accepted when tok_valid=1 and tok_ready=1 in the same cycle.
  - On accept: tok_cnt increments.
    - If tok_last=1: go to FINISH.
    - Else if rom_index==DEPTH-1: err<=1, go to FINISH (overrun, no END found).
    - Else rom_index<=rom_index+1 and go to FETCH.
  - tok_valid drops in the cycle after accept.
- FINISH (one cycle): done=1, then go to IDLE.
- Latency:
  - start sampled in cycle 0, FETCH in cycle 1, tok_valid=1 from cycle 2.
  - With tok_ready held at 1, a new token is presented every 2 cycles.
  - Sequence "5,5,21,1,#" with tok_ready=1: done pulses in cycle 11.
- busy is 1 in FETCH, PRESENT and FINISH; it is 0 in IDLE.
- abort:
  - Has priority over every transition.
  - From any non-IDLE state: go to IDLE, tok_valid<=0, no done pulse, err unchanged.
- start while busy=1 is ignored.
- A start pulse in the same cycle as the done pulse is also ignored, because the state is FINISH, not IDLE.
- rom_index never exceeds DEPTH-1; there is no wrap-around.
- tok_cnt saturates at DEPTH.

Decomposition:
- Shared package calc_pkg:
  - Token constants: TOK_END=10, TOK_ADD=20, TOK_SUB=21, TOK_MUL=22, TOK_DIV=23.
  - Digit range bounds (0..9).
  - State enum for this block.
  - Function tok_class(code) returning DIGIT, OP, END or INVALID.
- One combinational sub-module, token_classifier: maps the 8-bit code to is_digit, is_op, is_end and is_invalid.
- The FSM, index counter and output registers live in rom_token_sequencer.

Test Plan:
- ROM = 5,5,21,1,10 with tok_ready=1 -> tokens 5,5,21,1,10 in that order.
  - tok_is_op=1 only on 21; tok_last=1 only on 10.
  - tok_cnt=5 and err=0 at the done pulse.
  - done pulses exactly once, in cycle 11 after start.
- Same ROM with tok_ready toggling 0/1 at random -> identical token sequence.
  - tok_data is stable while tok_valid=1 and tok_ready=0.
  - No token is dropped or duplicated.
- ROM = 3,7,99 -> tokens 3 and 7 accepted; 99 is never presented.
  - err=1, done pulses, tok_cnt=2.
- DEPTH=4 with ROM = 1,2,3,4 (no END) -> four tokens accepted.
  - err=1 after the token at index 3; rom_index never reaches 4.
- abort asserted during PRESENT of the second token -> IDLE next cycle.
  - tok_valid=0, busy=0, no done pulse.
  - A following start restarts from index 0 with tok_cnt=0.
- Reset and start collisions:
  - rst=0 during PRESENT -> all outputs 0 immediately (asynchronous).
  - start while busy=1 -> no effect on rom_index or tok_cnt.
